// File: rtl/ghostchip_pkg.sv
// Shared types and constants for the ghostchip video memory subsystem.
package ghostchip_pkg;

  localparam int unsigned HiresWidth       = 128;
  localparam int unsigned HiresHeight      = 64;
  localparam int unsigned LoresWidth       = 64;
  localparam int unsigned LoresHeight      = 32;
  localparam int unsigned StreakMaxDefault = 3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } arb_state_e;

  typedef enum logic [1:0] {
    WinNone,
    WinVd,
    WinClr,
    WinCpu
  } arb_win_e;

endpackage

// File: rtl/vram_clear_seq.sv
// Clear-screen address sweep: raster order over the extent latched at start.
module vram_clear_seq
  import ghostchip_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       step,
  input  logic       hires,
  output logic [6:0] hpos,
  output logic [5:0] vpos,
  output logic       last
);

  logic [6:0] hpos_q, hpos_d, hmax;
  logic [5:0] vpos_q, vpos_d, vmax;
  logic       hires_q, hires_d;

  always_comb begin
    hmax = hires_q ? 7'(HiresWidth - 1) : 7'(LoresWidth - 1);
    vmax = hires_q ? 6'(HiresHeight - 1) : 6'(LoresHeight - 1);
    hpos = hpos_q;
    vpos = vpos_q;
    last = (hpos_q == hmax) && (vpos_q == vmax);
  end

  // A restart outranks a step in the same cycle.
  always_comb begin
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    hires_d = hires_q;
    if (start) begin
      hpos_d  = '0;
      vpos_d  = '0;
      hires_d = hires;
    end else if (step) begin
      if (hpos_q == hmax) begin
        hpos_d = '0;
        vpos_d = (vpos_q == vmax) ? '0 : vpos_q + 6'd1;
      end else begin
        hpos_d = hpos_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      hires_q <= 1'b0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hires_q <= hires_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between video drive, screen clear and CPU,
// one access per two cycles with a bounded vdrive streak.
module vram_arbiter
  import ghostchip_pkg::*;
#(
  parameter int unsigned STREAK_MAX = StreakMaxDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hires,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [6:0] cpu_hpos,
  input  logic [5:0] cpu_vpos,
  input  logic [1:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [1:0] cpu_rdata,
  input  logic       vd_req,
  input  logic [6:0] vd_hpos,
  input  logic [5:0] vd_vpos,
  output logic       vd_ack,
  output logic [1:0] vd_rdata,
  input  logic       clr_start,
  output logic       clr_busy,
  output logic       mem_en,
  output logic       mem_we,
  output logic [6:0] mem_hpos,
  output logic [5:0] mem_vpos,
  output logic [1:0] mem_din,
  input  logic [1:0] mem_dout
);

  localparam logic [1:0] StreakCap = 2'(STREAK_MAX);

  arb_state_e state_q, state_d;
  arb_win_e   win_q, win_d, grant;
  logic [1:0] streak_q, streak_d;
  logic       busy_q, busy_d;
  logic       clr_last_q, clr_last_d;
  logic [6:0] hpos_q, hpos_d;
  logic [5:0] vpos_q, vpos_d;
  logic       we_q, we_d;
  logic [1:0] din_q, din_d;

  logic [6:0] seq_hpos;
  logic [5:0] seq_vpos;
  logic       seq_last;
  logic       arb_en, clr_pend, cpu_pend, others_pend, vd_skip;

  vram_clear_seq u_clear_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (clr_start),
    .step  (grant == WinClr),
    .hires (hires),
    .hpos  (seq_hpos),
    .vpos  (seq_vpos),
    .last  (seq_last)
  );

  always_comb begin
    arb_en      = (state_q == StIdle) || (state_q == StDone);
    clr_pend    = busy_q;
    cpu_pend    = cpu_req && !busy_q;
    others_pend = clr_pend || cpu_pend;
    vd_skip     = others_pend && (streak_q == StreakCap);
    grant       = WinNone;
    if (arb_en) begin
      if (vd_req && !vd_skip) begin
        grant = WinVd;
      end else if (clr_pend) begin
        grant = WinClr;
      end else if (cpu_pend) begin
        grant = WinCpu;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    streak_d   = streak_q;
    busy_d     = busy_q;
    clr_last_d = clr_last_q;
    hpos_d     = hpos_q;
    vpos_d     = vpos_q;
    we_d       = we_q;
    din_d      = din_q;

    case (state_q)
      StIssue: state_d = StDone;
      StIdle, StDone: begin
        win_d   = grant;
        state_d = (grant == WinNone) ? StIdle : StIssue;
      end
      default: state_d = StIdle;
    endcase

    unique case (grant)
      WinVd: begin
        hpos_d = vd_hpos;
        vpos_d = vd_vpos;
        we_d   = 1'b0;
        din_d  = 2'b00;
        // The streak only grows while someone else is actually waiting.
        if (!others_pend) begin
          streak_d = 2'd0;
        end else begin
          streak_d = (streak_q == StreakCap) ? streak_q : streak_q + 2'd1;
        end
      end
      WinClr: begin
        hpos_d     = seq_hpos;
        vpos_d     = seq_vpos;
        we_d       = 1'b1;
        din_d      = 2'b00;
        clr_last_d = seq_last && !clr_start;
        streak_d   = 2'd0;
      end
      WinCpu: begin
        hpos_d   = cpu_hpos;
        vpos_d   = cpu_vpos;
        we_d     = cpu_we;
        din_d    = cpu_we ? cpu_wdata : 2'b00;
        streak_d = 2'd0;
      end
      default: ;
    endcase

    // Busy drops entering DONE of the final write so that DONE already
    // arbitrates as if the clear were finished.
    if (clr_start) begin
      busy_d = 1'b1;
    end else if ((state_q == StIssue) && (win_q == WinClr) && clr_last_q) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      win_q      <= WinNone;
      streak_q   <= 2'd0;
      busy_q     <= 1'b0;
      clr_last_q <= 1'b0;
      hpos_q     <= '0;
      vpos_q     <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      streak_q   <= streak_d;
      busy_q     <= busy_d;
      clr_last_q <= clr_last_d;
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
      we_q       <= we_d;
      din_q      <= din_d;
    end
  end

  always_comb begin
    mem_en    = (state_q == StIssue);
    mem_we    = mem_en && we_q;
    mem_hpos  = mem_en ? hpos_q : '0;
    mem_vpos  = mem_en ? vpos_q : '0;
    mem_din   = mem_en ? din_q : '0;
    vd_ack    = (state_q == StDone) && (win_q == WinVd);
    cpu_ack   = (state_q == StDone) && (win_q == WinCpu);
    vd_rdata  = vd_ack ? mem_dout : '0;
    cpu_rdata = cpu_ack ? mem_dout : '0;
    clr_busy  = busy_q;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus pushes expected memory
// accesses and acks; a negedge monitor pops and compares them.
module tb_vram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hires = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [6:0] cpu_hpos = '0;
  logic [5:0] cpu_vpos = '0;
  logic [1:0] cpu_wdata = '0;
  logic       cpu_ack;
  logic [1:0] cpu_rdata;
  logic       vd_req = 1'b0;
  logic [6:0] vd_hpos = '0;
  logic [5:0] vd_vpos = '0;
  logic       vd_ack;
  logic [1:0] vd_rdata;
  logic       clr_start = 1'b0;
  logic       clr_busy;
  logic       mem_en, mem_we;
  logic [6:0] mem_hpos;
  logic [5:0] mem_vpos;
  logic [1:0] mem_din;
  logic [1:0] mem_dout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic       we;
    logic [6:0] h;
    logic [5:0] v;
    logic [1:0] d;
    int         cyc;
  } mem_exp_t;

  typedef struct {
    logic       is_cpu;
    logic       chk;
    logic [1:0] rd;
    int         cyc;
  } ack_exp_t;

  mem_exp_t mq[$];
  ack_exp_t aq[$];
  mem_exp_t me;
  ack_exp_t ae;
  logic [1:0] vmem [128][64];

  vram_arbiter #(.STREAK_MAX(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hires     (hires),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_hpos  (cpu_hpos),
    .cpu_vpos  (cpu_vpos),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .vd_req    (vd_req),
    .vd_hpos   (vd_hpos),
    .vd_vpos   (vd_vpos),
    .vd_ack    (vd_ack),
    .vd_rdata  (vd_rdata),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_hpos  (mem_hpos),
    .mem_vpos  (mem_vpos),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port read-first memory with one cycle of read latency.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem_dout <= '0;
      for (int i = 0; i < 128; i++) for (int j = 0; j < 64; j++) vmem[i][j] <= '0;
    end else if (mem_en) begin
      mem_dout <= vmem[mem_hpos][mem_vpos];
      if (mem_we) vmem[mem_hpos][mem_vpos] <= mem_din;
    end
  end

  always @(negedge clk) begin
    if (mem_en) begin
      n_tests++;
      if (mq.size() == 0) begin
        n_fail++;
        $display("FAIL mem_unexpected: got we=%0b (%0d,%0d) din=%0d at cyc %0d, required none",
                 mem_we, mem_hpos, mem_vpos, mem_din, cyc);
      end else begin
        me = mq.pop_front();
        if (mem_we !== me.we || mem_hpos !== me.h || mem_vpos !== me.v || mem_din !== me.d ||
            (me.cyc >= 0 && cyc != me.cyc)) begin
          n_fail++;
          $display("FAIL mem_access: got we=%0b (%0d,%0d) din=%0d cyc %0d, required we=%0b (%0d,%0d) din=%0d cyc %0d",
                   mem_we, mem_hpos, mem_vpos, mem_din, cyc, me.we, me.h, me.v, me.d, me.cyc);
        end
      end
    end
    if (cpu_ack || vd_ack) begin
      n_tests++;
      if (aq.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: got cpu_ack=%0b vd_ack=%0b at cyc %0d, required none",
                 cpu_ack, vd_ack, cyc);
      end else begin
        ae = aq.pop_front();
        if ((cpu_ack && vd_ack) || cpu_ack !== ae.is_cpu || (ae.chk &&
            (ae.is_cpu ? cpu_rdata : vd_rdata) !== ae.rd) || (ae.cyc >= 0 && cyc != ae.cyc)) begin
          n_fail++;
          $display("FAIL ack: got cpu_ack=%0b vd_ack=%0b rdata=%0d/%0d cyc %0d, required cpu=%0b rd=%0d cyc %0d",
                   cpu_ack, vd_ack, cpu_rdata, vd_rdata, cyc, ae.is_cpu, ae.rd, ae.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [6:0] h, input logic [5:0] v,
                          input logic [1:0] d, input int c);
    mem_exp_t e;
    e.we = we; e.h = h; e.v = v; e.d = d; e.cyc = c;
    mq.push_back(e);
  endtask

  task automatic push_ack(input logic is_cpu, input logic chk, input logic [1:0] rd,
                          input int c);
    ack_exp_t e;
    e.is_cpu = is_cpu; e.chk = chk; e.rd = rd; e.cyc = c;
    aq.push_back(e);
  endtask

  task automatic wait_ack(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cpu_ack || vd_ack) && n < budget);
    if (!(cpu_ack || vd_ack)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no ack, required ack within %0d cycles", name, budget);
    end
  endtask

  // One isolated access from IDLE: memory at N+1, ack at N+2.
  task automatic single_op(input string name, input logic is_cpu, input logic we,
                           input logic [6:0] h, input logic [5:0] v, input logic [1:0] d,
                           input logic [1:0] rd);
    int c;
    c = cyc;
    push_mem(we, h, v, we ? d : 2'b00, c + 1);
    push_ack(is_cpu, !we, rd, c + 2);
    if (is_cpu) begin
      cpu_req = 1'b1; cpu_we = we; cpu_hpos = h; cpu_vpos = v; cpu_wdata = d;
    end else begin
      vd_req = 1'b1; vd_hpos = h; vd_vpos = v;
    end
    wait_ack(name, 8);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    vd_req  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int c;
    int n;
    int acks;
    repeat (3) @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_hpos", mem_hpos, 0);
    check("rst_mem_vpos", mem_vpos, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_vd_ack", vd_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_vd_rdata", vd_rdata, 0);
    check("rst_clr_busy", clr_busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Lone CPU write, then readbacks through both ports.
    single_op("cpu_write_10_5", 1'b1, 1'b1, 7'd10, 6'd5, 2'b11, 2'b00);
    single_op("vd_read_10_5", 1'b0, 1'b0, 7'd10, 6'd5, 2'b00, 2'b11);
    cpu_wdata = 2'b11;
    single_op("cpu_read_10_5", 1'b1, 1'b0, 7'd10, 6'd5, 2'b00, 2'b11);

    // Both held: V,V,V,C,V,V,V,C back to back.
    c = cyc;
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) push_mem(1'b0, 7'd2, 6'd2, 2'b00, c + 1 + 2 * k);
      else push_mem(1'b0, 7'd1, 6'd1, 2'b00, c + 1 + 2 * k);
      push_ack(k % 4 == 3, 1'b1, 2'b00, c + 2 + 2 * k);
    end
    vd_req = 1'b1; vd_hpos = 7'd1; vd_vpos = 6'd1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd2; cpu_vpos = 6'd2;
    acks = 0;
    n = 0;
    while (acks < 8 && n < 40) begin
      @(negedge clk);
      n++;
      if (cpu_ack || vd_ack) acks++;
    end
    check("streak_ack_count", acks, 8);
    vd_req = 1'b0;
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // Lores clear alone: 2048 writes, busy falls in DONE of the last.
    c = cyc;
    for (int k = 0; k < 2048; k++) push_mem(1'b1, 7'(k % 64), 6'(k / 64), 2'b00, c + 2 + 2 * k);
    hires = 1'b0;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    check("lores_busy_set", clr_busy, 1);
    while (cyc < c + 4096) @(negedge clk);
    check("lores_busy_last_issue", clr_busy, 1);
    @(negedge clk);
    check("lores_busy_clear", clr_busy, 0);
    @(negedge clk);
    single_op("vd_read_cleared", 1'b0, 1'b0, 7'd10, 6'd5, 2'b00, 2'b00);
    single_op("cpu_write_127_63", 1'b1, 1'b1, 7'd127, 6'd63, 2'b10, 2'b00);
    single_op("vd_read_127_63", 1'b0, 1'b0, 7'd127, 6'd63, 2'b00, 2'b10);

    // Hires clear with a CPU write waiting behind it.
    c = cyc;
    for (int k = 0; k < 8192; k++) begin
      push_mem(1'b1, 7'(k % 128), 6'(k / 128), 2'b00, c + 2 + 2 * k);
    end
    hires = 1'b1;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    hires = 1'b0;
    while (cyc < c + 10) @(negedge clk);
    push_mem(1'b1, 7'd20, 6'd10, 2'b01, c + 16386);
    push_ack(1'b1, 1'b0, 2'b00, c + 16387);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_hpos = 7'd20; cpu_vpos = 6'd10; cpu_wdata = 2'b01;
    wait_ack("cpu_write_during_clear", 20000);
    check("busy_low_at_cpu_ack", clr_busy, 0);
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    @(negedge clk);
    single_op("cpu_read_20_10", 1'b1, 1'b0, 7'd20, 6'd10, 2'b00, 2'b01);
    single_op("vd_read_hires_cleared", 1'b0, 1'b0, 7'd127, 6'd63, 2'b00, 2'b00);

    // Restart at sweep index 500.
    c = cyc;
    for (int k = 0; k <= 500; k++) push_mem(1'b1, 7'(k % 64), 6'(k / 64), 2'b00, c + 2 + 2 * k);
    for (int k = 0; k < 2048; k++) push_mem(1'b1, 7'(k % 64), 6'(k / 64), 2'b00, c + 1004 + 2 * k);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    while (cyc < c + 1002) @(negedge clk);
    check("restart_at_500_hpos", mem_hpos, 52);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    while (cyc < c + 5098) @(negedge clk);
    check("restart_busy_last_issue", clr_busy, 1);
    @(negedge clk);
    check("restart_busy_clear", clr_busy, 0);
    @(negedge clk);

    // Reset during ISSUE of a CPU read.
    c = cyc;
    push_mem(1'b0, 7'd3, 6'd3, 2'b00, c + 1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd3; cpu_vpos = 6'd3;
    @(negedge clk);
    check("pre_reset_issue", mem_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_mem_en", mem_en, 0);
    check("midrst_mem_hpos", mem_hpos, 0);
    check("midrst_mem_vpos", mem_vpos, 0);
    check("midrst_cpu_ack", cpu_ack, 0);
    check("midrst_cpu_rdata", cpu_rdata, 0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    check("exp_mem_drained", mq.size(), 0);
    check("exp_ack_drained", aq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
